// File: rtl/mem_req_pkg.sv
// rtl/mem_req_pkg.sv - shared state encoding and constants for the memory requester
package mem_req_pkg;

    localparam int DEF_RD_LATENCY = 2;
    localparam int LAT_W          = 3;

    // One-hot state bit positions
    localparam int IDLE_I     = 0;
    localparam int ISSUE_LO_I = 1;
    localparam int WAIT_LO_I  = 2;
    localparam int ISSUE_HI_I = 3;
    localparam int WAIT_HI_I  = 4;
    localparam int RESP_I     = 5;
    localparam int NUM_STATES = 6;

    typedef enum logic [NUM_STATES-1:0] {
        ST_IDLE     = 6'b000001 << IDLE_I,
        ST_ISSUE_LO = 6'b000001 << ISSUE_LO_I,
        ST_WAIT_LO  = 6'b000001 << WAIT_LO_I,
        ST_ISSUE_HI = 6'b000001 << ISSUE_HI_I,
        ST_WAIT_HI  = 6'b000001 << WAIT_HI_I,
        ST_RESP     = 6'b000001 << RESP_I
    } state_t;

    // Command-type encodings of cmd_write / cmd_word
    localparam logic CMD_LOAD  = 1'b0;
    localparam logic CMD_STORE = 1'b1;
    localparam logic CMD_BYTE  = 1'b0;
    localparam logic CMD_WORD  = 1'b1;

endpackage

// File: rtl/mem_req_lat_ctr.sv
// rtl/mem_req_lat_ctr.sv - load/decrement read-latency counter
module mem_req_lat_ctr
    import mem_req_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [LAT_W-1:0] count;

    // Load at the read strobe, then count down to zero while waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - LAT_W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/mem_requester.sv
// rtl/mem_requester.sv - splits CPU byte/word commands into memc byte beats
module mem_requester
    import mem_req_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = DEF_RD_LATENCY,
    parameter int PAGE_WRAP  = 0
) (
    input  logic                    req_clk,
    input  logic                    req_reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic                    cmd_word,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [2*DATA_WIDTH-1:0] cmd_wdata,
    output logic                    rsp_valid,
    output logic [2*DATA_WIDTH-1:0] rsp_rdata,
    input  logic                    memc_busy,
    output logic                    memc_rd_enable,
    output logic                    memc_wr_enable,
    output logic [ADDR_WIDTH-1:0]   memc_addr,
    output logic [DATA_WIDTH-1:0]   memc_wr_data,
    input  logic [DATA_WIDTH-1:0]   memc_rd_data
);

    // Counter holds L-1 after the strobe so the final WAIT cycle sees done
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LATENCY - 1);

    state_t                  state_q;
    state_t                  state_d;
    logic                    ready_en;
    logic                    accept;
    logic                    lat_load;
    logic                    lat_dec;
    logic                    lat_done;
    logic                    write_q;
    logic                    word_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH-1:0]   hi_addr;
    logic [DATA_WIDTH-1:0]   wdata_hi_q;
    logic [DATA_WIDTH-1:0]   rdata_lo_q;

    mem_req_lat_ctr u_lat_ctr (
        .clk      (req_clk),
        .rst_n    (req_reset),
        .load     (lat_load),
        .load_val (LAT_LOAD),
        .dec      (lat_dec),
        .done     (lat_done)
    );

    // High-beat address: linear increment or 6502-style wrap inside the page
    always_comb begin
        if (PAGE_WRAP != 0) begin
            hi_addr = {addr_q[ADDR_WIDTH-1:8], addr_q[7:0] + 8'd1};
        end else begin
            hi_addr = addr_q + ADDR_WIDTH'(1);
        end
    end

    // State register; cmd_ready stays low until one clock after reset release
    always_ff @(posedge req_clk or negedge req_reset) begin
        if (!req_reset) begin
            state_q  <= ST_IDLE;
            ready_en <= 1'b0;
        end else begin
            state_q  <= state_d;
            ready_en <= 1'b1;
        end
    end

    // Next state and strobes; strobes are gated combinationally by memc_busy
    always_comb begin
        state_d        = state_q;
        cmd_ready      = 1'b0;
        accept         = 1'b0;
        rsp_valid      = 1'b0;
        memc_rd_enable = 1'b0;
        memc_wr_enable = 1'b0;
        lat_load       = 1'b0;
        lat_dec        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = ready_en;
                if (cmd_valid && ready_en) begin
                    accept  = 1'b1;
                    state_d = ST_ISSUE_LO;
                end
            end
            ST_ISSUE_LO: begin
                if (!memc_busy) begin
                    if (write_q == CMD_STORE) begin
                        memc_wr_enable = 1'b1;
                        state_d        = (word_q == CMD_WORD) ? ST_ISSUE_HI : ST_RESP;
                    end else begin
                        memc_rd_enable = 1'b1;
                        lat_load       = 1'b1;
                        state_d        = ST_WAIT_LO;
                    end
                end
            end
            ST_WAIT_LO: begin
                lat_dec = 1'b1;
                if (lat_done) begin
                    state_d = (word_q == CMD_WORD) ? ST_ISSUE_HI : ST_RESP;
                end
            end
            ST_ISSUE_HI: begin
                if (!memc_busy) begin
                    if (write_q == CMD_STORE) begin
                        memc_wr_enable = 1'b1;
                        state_d        = ST_RESP;
                    end else begin
                        memc_rd_enable = 1'b1;
                        lat_load       = 1'b1;
                        state_d        = ST_WAIT_HI;
                    end
                end
            end
            ST_WAIT_HI: begin
                lat_dec = 1'b1;
                if (lat_done) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Command latch, beat address/data registers and read-data assembly
    always_ff @(posedge req_clk or negedge req_reset) begin
        if (!req_reset) begin
            write_q      <= 1'b0;
            word_q       <= 1'b0;
            addr_q       <= '0;
            wdata_hi_q   <= '0;
            rdata_lo_q   <= '0;
            memc_addr    <= '0;
            memc_wr_data <= '0;
            rsp_rdata    <= '0;
        end else begin
            if (accept) begin
                write_q    <= cmd_write;
                word_q     <= cmd_word;
                addr_q     <= cmd_addr;
                wdata_hi_q <= cmd_wdata[2*DATA_WIDTH-1:DATA_WIDTH];
                memc_addr  <= cmd_addr;
                if (cmd_write == CMD_STORE) begin
                    memc_wr_data <= cmd_wdata[DATA_WIDTH-1:0];
                end
            end
            if ((state_q == ST_ISSUE_LO) && memc_wr_enable && (word_q == CMD_WORD)) begin
                memc_addr    <= hi_addr;
                memc_wr_data <= wdata_hi_q;
            end
            if ((state_q == ST_WAIT_LO) && lat_done) begin
                if (word_q == CMD_WORD) begin
                    rdata_lo_q <= memc_rd_data;
                    memc_addr  <= hi_addr;
                end else begin
                    rsp_rdata <= {{DATA_WIDTH{1'b0}}, memc_rd_data};
                end
            end
            if ((state_q == ST_WAIT_HI) && lat_done) begin
                rsp_rdata <= {memc_rd_data, rdata_lo_q};
            end
        end
    end

endmodule

// File: doc/mem_requester.md
# mem_requester

Initiator for the memory-controller request interface. Accepts byte or 16-bit little-endian load/store commands from the CPU core, splits each one into byte beats, and issues each beat to the memory controller only while the controller is not busy. It captures read data after a fixed read latency and returns one response per command. It sits between the 6502 core's bus logic and `memc`.

## Interface
Parameters:
- `ADDR_WIDTH`, 16, address width.
- `DATA_WIDTH`, 8, controller data width; one beat moves one byte.
- `RD_LATENCY`, 2, cycles from the read-enable cycle to the `memc_rd_data` valid cycle; legal range 1..7.
- `PAGE_WRAP`, 0, when 1 the high-byte address of a word access wraps within the page (6502 indirect-JMP behaviour).

Ports:
- `req_clk`  in  1  sole clock; all logic on the rising edge.
- `req_reset`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid` and `cmd_ready` are both high.
- `cmd_write`  in  1  1 = store, 0 = load.
- `cmd_word`  in  1  1 = 16-bit access, 0 = byte access.
- `cmd_addr`  in  16  start address.
- `cmd_wdata`  in  16  store data; `[7:0]` is the low byte.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  16  load data; byte loads are zero-extended.
- `memc_busy`  in  1  controller busy; no beat is issued while this is high.
- `memc_rd_enable`  out  1  read strobe, one cycle per beat.
- `memc_wr_enable`  out  1  write strobe, one cycle per beat.
- `memc_addr`  out  16  beat address.
- `memc_wr_data`  out  8  beat write data.
- `memc_rd_data`  in  8  read data, valid `RD_LATENCY` cycles after the read strobe.

## Operation
- States:
  - IDLE: `cmd_ready`=1.
  - ISSUE_LO
  - WAIT_LO: read only.
  - ISSUE_HI
  - WAIT_HI: read only.
  - RESP
- Transitions:
  - IDLE goes to ISSUE_LO on accept. The command fields are latched at accept.
  - ISSUE_x holds until `memc_busy`=0. In the cycle where `memc_busy`=0, the strobe is asserted and the state advances:
    - read: to WAIT_x;
    - word write: to ISSUE_HI after the low beat;
    - byte write, or the high beat of a word write: to RESP.
  - WAIT_x counts `RD_LATENCY` cycles and samples `memc_rd_data` in the final count cycle. It then advances to ISSUE_HI (word load, low beat) or to RESP.
  - RESP asserts `rsp_valid` for one cycle and returns to IDLE.
- Address of the high beat:
  - `PAGE_WRAP`=0: `addr+1` modulo 2^16, so 16'hFFFF wraps to 16'h0000.
  - `PAGE_WRAP`=1: `{addr[15:8], addr[7:0]+1}`, so 16'h12FF reads its high byte from 16'h1200.
- `memc_addr` and `memc_wr_data` are driven in ISSUE cycles and hold their last values otherwise.
- `memc_rd_enable` and `memc_wr_enable` are never high together, and never high while `memc_busy` is high.
- `memc_busy` is ignored in WAIT states, so a read that is already in flight always completes.
- `cmd_valid` while `cmd_ready`=0 is ignored; the core holds the command until it is accepted.
- A store also produces a `rsp_valid` pulse; `rsp_rdata` is unchanged on stores.
- Reset, including mid-operation: asynchronous return to IDLE.
  - Any in-flight command is dropped and no response is produced.
  - Every output goes to 0, and `cmd_ready` is held at 0 while `req_reset` is low.
  - `cmd_ready` is 1 from the first cycle after `req_reset` is released.

## Timing
- Cycle 0 is the accept cycle. All figures below assume `memc_busy` low throughout, with L = `RD_LATENCY`.
- Byte load: strobe in cycle 1, data sampled in cycle 1+L, `rsp_valid` in cycle 2+L (cycle 4 for L=2).
- Word load: low strobe in cycle 1, high strobe in cycle 2+L, `rsp_valid` in cycle 3+2L (cycle 7 for L=2).
- Byte store: strobe in cycle 1, `rsp_valid` in cycle 2.
- Word store: strobes in cycles 1 and 2, `rsp_valid` in cycle 3.
- Each cycle of `memc_busy` high during an ISSUE state adds exactly one cycle.
- Back-to-back commands: the next accept is possible in the cycle after RESP.
- `rsp_rdata` is stable from RESP until the next load response.

## Structure
- Shared package `mem_req_pkg` holds:
  - the state encoding (one-hot, index localparams);
  - the default `RD_LATENCY`;
  - command-type constants.
- One sub-module, `mem_req_lat_ctr`: a 3-bit load/decrement latency counter with a `done` output, used in the WAIT states.

## Test plan
- Byte load from 16'h0200 holding 8'hA5, L=2, busy low -> one read strobe with `memc_addr`=16'h0200 in cycle 1; `rsp_valid` in cycle 4 with `rsp_rdata`=16'h00A5.
- Word load from 16'hFFFF with 16'hFFFF=8'h34 and 16'h0000=8'h12, `PAGE_WRAP`=0 -> strobes at 16'hFFFF then 16'h0000; `rsp_rdata`=16'h1234 in cycle 7.
- Same word load from 16'h12FF with `PAGE_WRAP`=1 -> high beat addressed at 16'h1200.
- Word store of 16'hBEEF to 16'h0300 with `memc_busy` high for 3 cycles after accept -> write strobes at 16'h0300/8'hEF in cycle 4 and 16'h0301/8'hBE in cycle 5; `rsp_valid` in cycle 6; no strobe while busy.
- `req_reset` low in a WAIT_LO cycle -> all outputs 0 immediately; no `rsp_valid`; `cmd_ready`=1 in the cycle after release, and the next command completes normally.
